// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - two-requester round-robin arbiter in front of one shared bitwise unit
//
// Purpose:
//   Two requesters compete for a single bitwise logic unit (NOT/AND/OR/XOR).
//   At most one operation is accepted per cycle. The result lands in a
//   one-entry result register one cycle after acceptance and stays there
//   until the consumer takes it. Contention is resolved round-robin.
//   Per-requester saturating counters track accepted operations.
//
// Ports:
//   clock        rising-edge clock for all state
//   reset        synchronous, active-high reset
//   reqN_valid   requester N presents an operation
//   reqN_op      opcode: 00 NOT a, 01 AND, 10 OR, 11 XOR
//   reqN_a/b     operands (b unused for NOT)
//   reqN_ready   requester N operation accepted this cycle (combinational)
//   resp_valid   result register holds an unconsumed result
//   resp_ready   consumer takes the result this cycle
//   resp_id      requester that owns the result
//   resp_result  computed result
//   count0/1     saturating count of accepted operations per requester

module logic_op_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_result,
  output logic [15:0]      count0,
  output logic [15:0]      count1
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state;

  // Index of the requester granted most recently; the other one wins a tie.
  logic rr_ptr;

  logic             slot_open;
  logic             pick1;
  logic             xfer0;
  logic             xfer1;
  logic             xfer;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] alu_out;

  // The slot is open when the result register is empty or is being drained
  // this very cycle, which lets one result per cycle flow back-to-back.
  // Reset closes the slot so nothing is accepted while it is asserted.
  assign slot_open = !reset && ((state == IDLE) || resp_ready);

  // With both requesters valid the one not granted last wins; otherwise the
  // single valid requester wins. With neither valid pick1 is 0 but both
  // readies stay low because they are qualified by valid.
  assign pick1 = (req0_valid && req1_valid) ? (rr_ptr == 1'b0) : req1_valid;

  assign req0_ready = slot_open && req0_valid && !pick1;
  assign req1_ready = slot_open && req1_valid &&  pick1;

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;
  assign xfer  = xfer0 || xfer1;

  // Operand mux feeding the single shared logic unit.
  always_comb begin
    sel_op = req0_op;
    sel_a  = req0_a;
    sel_b  = req0_b;
    if (xfer1) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end
  end

  always_comb begin
    alu_out = '0;
    case (sel_op)
      2'b00:   alu_out = ~sel_a;
      2'b01:   alu_out = sel_a & sel_b;
      2'b10:   alu_out = sel_a | sel_b;
      default: alu_out = sel_a ^ sel_b;
    endcase
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      rr_ptr      <= 1'b1;
      count0      <= 16'd0;
      count1      <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state <= HOLD;
            resp_valid <= 1'b1;
          end
        end
        HOLD: begin
          // Without resp_ready the slot is closed, so xfer cannot be high and
          // the result register simply holds.
          if (resp_ready && !xfer) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase

      if (xfer) begin
        resp_result <= alu_out;
        resp_id     <= xfer1;
        rr_ptr      <= xfer1;
      end

      if (xfer0 && (count0 != 16'hFFFF)) begin
        count0 <= count0 + 16'd1;
      end
      if (xfer1 && (count1 != 16'hFFFF)) begin
        count1 <= count1 + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0_valid, req1_valid;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         resp_valid, resp_ready, resp_id;
  logic [W-1:0] resp_result;
  logic [15:0]  count0, count1;

  logic_op_arbiter #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_result(resp_result),
    .count0(count0), .count1(count1)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural model: what the result register, owner, last winner and
  // counters must be after every clock edge.
  bit           m_known = 0;
  bit           m_valid;
  bit           m_id;
  logic [W-1:0] m_result;
  int           m_last;
  int           m_cnt[2];

  // Readies seen on the most recent step, for literal checks.
  logic s_r0, s_r1;

  function automatic logic [W-1:0] op_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return ~a;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven. Compare at the falling edge,
  // advance the model, then return #1 after the rising edge.
  task automatic step(output int gnt);
    int g;
    @(negedge clock);
    g = -1;
    if (!reset && m_known && (!m_valid || resp_ready)) begin
      if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
    end
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    if (m_known || reset) begin
      check("req0_ready", 64'(req0_ready), 64'(g == 0));
      check("req1_ready", 64'(req1_ready), 64'(g == 1));
    end
    if (m_known) begin
      check("resp_valid",  64'(resp_valid),  64'(m_valid));
      check("resp_id",     64'(resp_id),     64'(m_id));
      check("resp_result", 64'(resp_result), 64'(m_result));
      check("count0",      64'(count0),      64'(m_cnt[0]));
      check("count1",      64'(count1),      64'(m_cnt[1]));
    end
    if (reset) begin
      m_known = 1; m_valid = 0; m_id = 0; m_result = '0; m_last = 1;
      m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (g >= 0) begin
      m_valid  = 1;
      m_id     = (g == 1);
      m_result = (g == 0) ? op_fn(req0_op, req0_a, req0_b) : op_fn(req1_op, req1_a, req1_b);
      m_last   = g;
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else if (resp_ready) begin
      m_valid = 0;
    end
    @(posedge clock);
    #1;
    gnt = g;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0;
    req0_op = 0; req1_op = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    int g;
    reset = 1;
    step(g);
    step(g);
    reset = 0;
  endtask

  int g;
  int seq[4];
  bit pend0, pend1;
  logic [W-1:0] held;

  initial begin
    idle_inputs();
    resp_ready = 1;
    reset = 1;
    @(posedge clock); #1;
    do_reset();
    check("reset resp_valid", 64'(resp_valid), 64'(0));
    check("reset resp_result", 64'(resp_result), 64'(0));
    check("reset count0", 64'(count0), 64'(0));

    // First operation: NOT from requester 0.
    req0_valid = 1; req0_op = 2'd0; req0_a = 32'h0000FFFF;
    step(g);
    check("first req0_ready", 64'(s_r0), 64'(1));
    req0_valid = 0;
    check("first resp_valid", 64'(resp_valid), 64'(1));
    check("first resp_id", 64'(resp_id), 64'(0));
    check("first resp_result", 64'(resp_result), 64'(32'hFFFF0000));
    step(g);

    // Round-robin under full contention.
    do_reset();
    req0_valid = 1; req0_op = 2'd1; req0_a = 32'h12345678; req0_b = 32'h0F0F0F0F;
    req1_valid = 1; req1_op = 2'd3; req1_a = 32'hAAAAAAAA; req1_b = 32'hFFFFFFFF;
    for (int i = 0; i < 4; i++) begin
      step(g);
      seq[i] = s_r1 ? 1 : (s_r0 ? 0 : -1);
      if (i == 1) begin
        check("xor resp_id", 64'(resp_id), 64'(1));
        check("xor resp_result", 64'(resp_result), 64'(32'h55555555));
      end
      if (i == 0) check("and resp_result", 64'(resp_result), 64'(32'h02040608));
    end
    check("rr grant0", 64'(seq[0]), 64'(0));
    check("rr grant1", 64'(seq[1]), 64'(1));
    check("rr grant2", 64'(seq[2]), 64'(0));
    check("rr grant3", 64'(seq[3]), 64'(1));
    idle_inputs();
    step(g);

    // Back-pressure: result held, readies low, then same-cycle accept.
    resp_ready = 0;
    req0_valid = 1; req0_op = 2'd2; req0_a = 32'hF0000000; req0_b = 32'h0000000F;
    step(g);
    req0_valid = 0;
    held = resp_result;
    check("hold first", 64'(held), 64'(32'hF000000F));
    req1_valid = 1; req1_op = 2'd0; req1_a = 32'h00000000;
    for (int i = 0; i < 5; i++) begin
      step(g);
      check("hold r0 low", 64'(s_r0), 64'(0));
      check("hold r1 low", 64'(s_r1), 64'(0));
      check("hold result", 64'(resp_result), 64'(32'hF000000F));
    end
    resp_ready = 1;
    step(g);
    check("release r1", 64'(s_r1), 64'(1));
    req1_valid = 0;
    check("release result", 64'(resp_result), 64'(32'hFFFFFFFF));
    check("release id", 64'(resp_id), 64'(1));

    // Reset while a result is pending.
    resp_ready = 0;
    reset = 1;
    step(g);
    reset = 0;
    check("rst-hold resp_valid", 64'(resp_valid), 64'(0));
    check("rst-hold count0", 64'(count0), 64'(0));
    check("rst-hold count1", 64'(count1), 64'(0));
    resp_ready = 1;
    req1_valid = 1; req1_op = 2'd1; req1_a = 32'hFFFF0000; req1_b = 32'h0FF00FF0;
    step(g);
    req1_valid = 0;
    check("rst-hold r1 grant", 64'(resp_id), 64'(1));
    check("rst-hold r1 result", 64'(resp_result), 64'(32'h0FF00000));
    step(g);

    // Every opcode from each requester with random operands.
    for (int r = 0; r < 2; r++) begin
      for (int op = 0; op < 4; op++) begin
        for (int k = 0; k < 8; k++) begin
          idle_inputs();
          if (r == 0) begin
            req0_valid = 1; req0_op = 2'(op); req0_a = $urandom; req0_b = $urandom;
          end else begin
            req1_valid = 1; req1_op = 2'(op); req1_a = $urandom; req1_b = $urandom;
          end
          step(g);
        end
      end
    end
    idle_inputs();
    step(g);

    // Random traffic: requests held until granted, random back-pressure,
    // occasional reset.
    pend0 = 0; pend1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pend0) begin
        req0_valid = ($urandom_range(0, 1) == 1);
        req0_op = 2'($urandom_range(0, 3)); req0_a = $urandom; req0_b = $urandom;
      end
      if (!pend1) begin
        req1_valid = ($urandom_range(0, 1) == 1);
        req1_op = 2'($urandom_range(0, 3)); req1_a = $urandom; req1_b = $urandom;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step(g);
      pend0 = req0_valid && (g != 0) && !reset;
      pend1 = req1_valid && (g != 1) && !reset;
      reset = 0;
    end
    idle_inputs();
    resp_ready = 1;

    // Counter saturation.
    do_reset();
    req0_valid = 1; req0_op = 2'd3; req0_a = 32'h1; req0_b = 32'h3;
    for (int i = 0; i < 65537; i++) step(g);
    req0_valid = 0;
    check("sat count0", 64'(count0), 64'(16'hFFFF));
    check("sat count1", 64'(count1), 64'(0));
    step(g);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand and result width in bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_op  input  2  requester 0 opcode: 00 NOT a, 01 AND, 10 OR, 11 XOR.
REQ-006 req0_a, req0_b  input  WIDTH each  requester 0 operands; b is ignored for NOT.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready  same widths and meanings for requester 1.
REQ-009 resp_valid  output  1  result register holds an unconsumed result.
REQ-010 resp_ready  input  1  consumer accepts the result this cycle.
REQ-011 resp_id  output  1  index of the requester that owns the result.
REQ-012 resp_result  output  WIDTH  computed result.
REQ-013 count0, count1  output  16 each  saturating count of operations accepted per requester.

Function
REQ-014 One shared bitwise unit; at most one request is accepted per cycle.
REQ-015 FSM states: IDLE (result register empty), HOLD (result register full).
REQ-016 Accept slot open = IDLE, or HOLD with resp_ready=1 in the same cycle.
REQ-017 Grant, only when the slot is open: a single valid requester wins; both valid -> the requester not granted last wins (round-robin).
REQ-018 reqN_ready is combinational, high only for the granted requester in a cycle where the slot is open, and never high for a requester whose valid is low.
REQ-019 Transfer occurs when reqN_valid and reqN_ready are both high; result = ~a, a&b, a|b, or a^b per opcode, captured in full WIDTH with no truncation.
REQ-020 Latency: a transfer in cycle N gives resp_valid=1 with the result and resp_id in cycle N+1.
REQ-021 IDLE -> HOLD on transfer; HOLD -> IDLE on resp_ready with no new transfer; HOLD -> HOLD on resp_ready with a new transfer (back-to-back, one result per cycle sustained).
REQ-022 HOLD with resp_ready=0: resp_result and resp_id are held stable and both reqN_ready are low.
REQ-023 resp_ready while resp_valid=0 has no effect.
REQ-024 The round-robin pointer updates only on a transfer, to the granted index.
REQ-025 countN increments by 1 on each requester-N transfer and saturates at 16'hFFFF (no wrap).
REQ-026 Inputs of a requester that is not granted are ignored; that requester holds its request (valid is not withdrawn by protocol).

Reset
REQ-027 reset high at a clock edge: state=IDLE, resp_valid=0, resp_id=0, resp_result=0, count0=count1=0, round-robin pointer=1 so requester 0 wins the first contention.
REQ-028 While reset is high, req0_ready=req1_ready=0 and no transfer occurs.
REQ-029 Reset during HOLD discards the pending result; no response for it appears after reset.

Verification
REQ-030 After reset, req0 NOT a=32'h0000FFFF -> req0_ready=1 in that cycle; next cycle resp_valid=1, resp_id=0, resp_result=32'hFFFF0000.
REQ-031 req0 and req1 valid together for 4 cycles with resp_ready=1 -> grants 0,1,0,1; req1 XOR a=32'hAAAAAAAA b=32'hFFFFFFFF returns 32'h55555555 with resp_id=1.
REQ-032 Result pending with resp_ready=0 for 5 cycles -> resp_result unchanged, both readies low; resp_ready=1 -> pending request accepted that same cycle, new result next cycle.
REQ-033 Reset asserted while resp_valid=1 -> next cycle resp_valid=0, counters 0; req1 alone then wins with resp_id=1.
REQ-034 Counter saturation: 65537 req0 transfers -> count0=16'hFFFF, count1=0.
REQ-035 Exhaustive op check: random a,b for each opcode from both requesters -> resp_result matches ~a, a&b, a|b, a^b; pass count printed.
